// File: rtl/tt_link_pkg.sv
// Shared types and constants for the pin-link receiver.
// Holds the handshake FSM states, uio bit positions and the output-enable pattern.
package tt_link_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } link_state_t;

   localparam int         LINK_ACK_BIT = 1;
   localparam int         LINK_REQ_BIT = 0;
   localparam logic [1:0] LINK_OE      = 2'b10;

   // Saturating 8-bit increment for the stall counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/tt_pin_link_rx_if.sv
// Pin-side and consumer-side signal bundle of the pin-link receiver.
// Ports: pin_data/pin_req/pin_ack/pin_oe (host), rd_* / level / ovf_cnt (core).
interface tt_pin_link_rx_if #(
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    pin_data;
   logic          pin_req;
   logic          pin_ack;
   logic [1:0]    pin_oe;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready;
   logic [LW-1:0] level;
   logic [7:0]    ovf_cnt;

   modport master (
      output pin_data, pin_req, rd_ready,
      input  pin_ack, pin_oe, rd_data, rd_valid, level, ovf_cnt
   );

   modport slave (
      input  pin_data, pin_req, rd_ready,
      output pin_ack, pin_oe, rd_data, rd_valid, level, ovf_cnt
   );
endinterface

// File: rtl/tt_link_fifo.sv
// Synchronous byte FIFO with occupancy count; storage is not reset.
// Ports: push_i/wdata_i, pop_i, rdata_o (head, 0 when empty), full_o, empty_o, level_o.
module tt_link_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push_i,
   input  logic [7:0]              wdata_i,
   input  logic                    pop_i,
   output logic [7:0]              rdata_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [$clog2(DEPTH):0]  level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;
   // Head read through the registered pointer; forced to 0 when empty.
   assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

   // Push at full is refused even if a pop happens the same cycle.
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case (1'b1)
         (do_push && !do_pop): cnt_d = cnt_q + 1'b1;
         (do_pop && !do_push): cnt_d = cnt_q - 1'b1;
         default:              cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/tt_pin_link_rx.sv
// Host-to-design byte receiver: 4-phase req/ack on pins into a small FIFO.
// Ports: clk, rst (sync, high), ena, bus (slave); TT_PIN_LINK_SYNC_EN adds 2-flop pin sync.
module tt_pin_link_rx
   import tt_link_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic              clk,
   input logic              rst,
   input logic              ena,
   tt_pin_link_rx_if.slave  bus
);
   logic                   req_s;
   logic [7:0]             data_s;
   logic                   full, empty;
   logic                   push, stall;
   logic [$clog2(DEPTH):0] level;
   link_state_t            state_q;
   logic                   ack_q;
   logic [7:0]             ovf_q;

`ifdef TT_PIN_LINK_SYNC_EN
   logic [1:0] req_sync_q;
   logic [7:0] data_s1_q, data_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         req_sync_q <= '0;
         data_s1_q  <= '0;
         data_s2_q  <= '0;
      end else begin
         req_sync_q <= {req_sync_q[0], bus.pin_req};
         data_s1_q  <= bus.pin_data;
         data_s2_q  <= data_s1_q;
      end
   end

   assign req_s  = req_sync_q[1];
   assign data_s = data_s2_q;
`else
   assign req_s  = bus.pin_req;
   assign data_s = bus.pin_data;
`endif

   // A request in IDLE either writes (space) or stalls (full).
   assign push  = (state_q == IDLE) && ena && req_s && !full;
   assign stall = (state_q == IDLE) && ena && req_s && full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         ovf_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (push) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
               end
            end
            ACK: begin
               if (!req_s) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
         if (stall) ovf_q <= sat_inc8(ovf_q);
      end
   end

   tt_link_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i (data_s),
      .pop_i   (bus.rd_ready),
      .rdata_o (bus.rd_data),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign bus.pin_ack  = ack_q;
   assign bus.pin_oe   = LINK_OE;
   assign bus.rd_valid = !empty;
   assign bus.level    = level;
   assign bus.ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_tt_pin_link_rx.sv
// Self-checking bench for tt_pin_link_rx: directed scenarios plus a
// randomized host/consumer run checked against a queue model.
module tb_tt_pin_link_rx;
   localparam int DEPTH = 4;
`ifdef TT_PIN_LINK_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst;
   logic ena;

   tt_pin_link_rx_if #(.DEPTH(DEPTH)) bus ();

   tt_pin_link_rx #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Pop everything currently held, checking against the given bytes.
   task automatic drain(input logic [7:0] exp[$], input string nm);
      foreach (exp[i]) begin
         n_tests++;
         if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp[i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got valid=%b data=%h, want valid=1 data=%h",
                     nm, i, bus.rd_valid, bus.rd_data, exp[i]);
         end
         bus.rd_ready = 1'b1;
         tick(1);
         bus.rd_ready = 1'b0;
      end
      n_tests++;
      if (bus.level !== '0) begin
         n_fail++;
         $display("FAIL %s_empty: level=%0d want 0", nm, bus.level);
      end
   endtask

   // Full 4-phase handshake with bounded waits.
   task automatic send_byte(input logic [7:0] d);
      int t;
      bus.pin_data = d;
      bus.pin_req  = 1'b1;
      t = 0;
      while (bus.pin_ack !== 1'b1 && t < 50) begin
         tick(1);
         t++;
      end
      n_tests++;
      if (bus.pin_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL send_ack_rise: ack=%b want 1 (data %h)", bus.pin_ack, d);
      end
      bus.pin_req = 1'b0;
      t = 0;
      while (bus.pin_ack !== 1'b0 && t < 50) begin
         tick(1);
         t++;
      end
      n_tests++;
      if (bus.pin_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL send_ack_fall: ack=%b want 0", bus.pin_ack);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      ena          = 1'b0;
      bus.pin_req  = 1'b0;
      bus.pin_data = 8'h00;
      bus.rd_ready = 1'b0;
      tick(2);
      n_tests++;
      if (bus.pin_ack !== 1'b0 || bus.pin_oe !== 2'b10 ||
          bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h00 ||
          bus.level !== '0 || bus.ovf_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL reset: ack=%b oe=%b valid=%b data=%h level=%0d ovf=%0d, want 0 10 0 00 0 0",
                  bus.pin_ack, bus.pin_oe, bus.rd_valid, bus.rd_data,
                  bus.level, bus.ovf_cnt);
      end
      rst = 1'b0;
      ena = 1'b1;
      tick(1);
   endtask

   task automatic test_single();
      logic [7:0] e[$];
      bus.pin_data = 8'hA5;
      bus.pin_req  = 1'b1;
      tick(LAT - 1);
      n_tests++;
      if (bus.pin_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early_ack: ack=%b want 0", bus.pin_ack);
      end
      tick(1);
      n_tests++;
      if (bus.pin_ack !== 1'b1 || bus.rd_valid !== 1'b1 ||
          bus.rd_data !== 8'hA5 || bus.level !== 1) begin
         n_fail++;
         $display("FAIL single: ack=%b valid=%b data=%h level=%0d, want 1 1 a5 1",
                  bus.pin_ack, bus.rd_valid, bus.rd_data, bus.level);
      end
      bus.pin_req = 1'b0;
      tick(LAT);
      n_tests++;
      if (bus.pin_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack_fall: ack=%b want 0", bus.pin_ack);
      end
      e = '{8'hA5};
      drain(e, "single_drain");
   endtask

   task automatic test_overflow();
      logic [7:0] e[$];
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      n_tests++;
      if (bus.level !== 4) begin
         n_fail++;
         $display("FAIL ovf_fill: level=%0d want 4", bus.level);
      end
      bus.pin_data = 8'h05;
      bus.pin_req  = 1'b1;
      tick(3);
      n_tests++;
      if (bus.pin_ack !== 1'b0 || bus.ovf_cnt !== 8'(3 - (LAT - 1))) begin
         n_fail++;
         $display("FAIL ovf_stall: ack=%b ovf=%0d, want 0 %0d",
                  bus.pin_ack, bus.ovf_cnt, 3 - (LAT - 1));
      end
      bus.rd_ready = 1'b1;
      tick(1);
      bus.rd_ready = 1'b0;
      n_tests++;
      if (bus.pin_ack !== 1'b0 || bus.level !== 3 || bus.rd_data !== 8'h02 ||
          bus.ovf_cnt !== 8'(4 - (LAT - 1))) begin
         n_fail++;
         $display("FAIL ovf_pop: ack=%b level=%0d data=%h ovf=%0d, want 0 3 02 %0d",
                  bus.pin_ack, bus.level, bus.rd_data, bus.ovf_cnt, 4 - (LAT - 1));
      end
      tick(1);
      n_tests++;
      if (bus.pin_ack !== 1'b1 || bus.level !== 4 ||
          bus.ovf_cnt !== 8'(4 - (LAT - 1))) begin
         n_fail++;
         $display("FAIL ovf_resume: ack=%b level=%0d ovf=%0d, want 1 4 %0d",
                  bus.pin_ack, bus.level, bus.ovf_cnt, 4 - (LAT - 1));
      end
      bus.pin_req = 1'b0;
      tick(LAT);
      e = '{8'h02, 8'h03, 8'h04, 8'h05};
      drain(e, "ovf_drain");
   endtask

   task automatic test_hold();
      logic [7:0] e[$];
      logic [7:0] d;
      d = 8'($urandom);
      bus.pin_data = d;
      bus.pin_req  = 1'b1;
      tick(10);
      n_tests++;
      if (bus.level !== 1 || bus.pin_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL hold: level=%0d ack=%b, want 1 1", bus.level, bus.pin_ack);
      end
      bus.pin_req = 1'b0;
      tick(LAT);
      e = '{d};
      drain(e, "hold_drain");
   endtask

   task automatic test_ena();
      logic [7:0] e[$];
      ena          = 1'b0;
      bus.pin_data = 8'h5A;
      bus.pin_req  = 1'b1;
      tick(5);
      n_tests++;
      if (bus.pin_ack !== 1'b0 || bus.level !== 0) begin
         n_fail++;
         $display("FAIL ena_low: ack=%b level=%0d, want 0 0", bus.pin_ack, bus.level);
      end
      ena = 1'b1;
      tick(1);
      n_tests++;
      if (bus.pin_ack !== 1'b1 || bus.level !== 1 || bus.rd_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL ena_high: ack=%b level=%0d data=%h, want 1 1 5a",
                  bus.pin_ack, bus.level, bus.rd_data);
      end
      ena         = 1'b0;
      bus.pin_req = 1'b0;
      tick(LAT);
      n_tests++;
      if (bus.pin_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL ena_low_release: ack=%b want 0", bus.pin_ack);
      end
      e = '{8'h5A};
      drain(e, "ena_drain");
      ena = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic [7:0] e[$];
      bus.pin_data = 8'h3C;
      bus.pin_req  = 1'b1;
      tick(LAT);
      n_tests++;
      if (bus.pin_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ack: ack=%b want 1", bus.pin_ack);
      end
      rst = 1'b1;
      tick(1);
      n_tests++;
      if (bus.pin_ack !== 1'b0 || bus.level !== 0) begin
         n_fail++;
         $display("FAIL rstmid_in_reset: ack=%b level=%0d, want 0 0",
                  bus.pin_ack, bus.level);
      end
      tick(1);
      rst = 1'b0;
      tick(LAT);
      n_tests++;
      if (bus.pin_ack !== 1'b1 || bus.level !== 1 || bus.rd_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL rstmid_rewrite: ack=%b level=%0d data=%h, want 1 1 3c",
                  bus.pin_ack, bus.level, bus.rd_data);
      end
      tick(5);
      n_tests++;
      if (bus.level !== 1) begin
         n_fail++;
         $display("FAIL rstmid_once: level=%0d want 1", bus.level);
      end
      bus.pin_req = 1'b0;
      tick(LAT);
      e = '{8'h3C};
      drain(e, "rstmid_drain");
   endtask

   // Random host and consumer; model is a byte queue fed on each ack rise.
   task automatic test_random();
      logic [7:0] q[$];
      logic [7:0] cur = 8'h00;
      logic       ack_prev = 1'b0;
      bit         pop_pend = 0;
      bit         stall_pend = 0;
      int         ovf_m = 0;
      int         sent = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (pop_pend) void'(q.pop_front());
         if (bus.pin_ack === 1'b1 && ack_prev === 1'b0) begin
            q.push_back(cur);
            sent++;
         end
         if (stall_pend && ovf_m < 255) ovf_m++;
         n_tests++;
         if (bus.level !== q.size() || bus.rd_valid !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL rand_level c=%0d: level=%0d valid=%b, want %0d %b",
                     c, bus.level, bus.rd_valid, q.size(), q.size() != 0);
         end
         if (q.size() != 0) begin
            n_tests++;
            if (bus.rd_data !== q[0]) begin
               n_fail++;
               $display("FAIL rand_data c=%0d: data=%h want %h", c, bus.rd_data, q[0]);
            end
         end
`ifndef TT_PIN_LINK_SYNC_EN
         n_tests++;
         if (bus.ovf_cnt !== 8'(ovf_m)) begin
            n_fail++;
            $display("FAIL rand_ovf c=%0d: ovf=%0d want %0d", c, bus.ovf_cnt, ovf_m);
         end
`endif
         ack_prev = bus.pin_ack;
         if (!bus.pin_req && bus.pin_ack === 1'b0 && $urandom_range(2) == 0) begin
            cur          = 8'($urandom);
            bus.pin_data = cur;
            bus.pin_req  = 1'b1;
         end else if (bus.pin_req && bus.pin_ack === 1'b1 && $urandom_range(1) == 0) begin
            bus.pin_req = 1'b0;
         end
         ena = ($urandom_range(7) != 0);
         if (c < 1500) bus.rd_ready = ($urandom_range(5) == 0);
         else          bus.rd_ready = ($urandom_range(1) == 0);
         pop_pend   = bus.rd_valid && bus.rd_ready;
         stall_pend = ena && bus.pin_req && (bus.pin_ack === 1'b0) &&
                      (bus.level == DEPTH);
      end
      n_tests++;
      if (sent < 50) begin
         n_fail++;
         $display("FAIL rand_activity: bytes=%0d want >=50", sent);
      end
      bus.pin_req  = 1'b0;
      bus.rd_ready = 1'b0;
      ena          = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_hold();
      test_ena();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
